// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling,
// a one-deep output register with valid/ready handshake, and
// frame-error / overrun pulses.
`timescale 1ns/1ps
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       serial_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overrun
);

  localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_error_q, frame_error_d;
  logic        overrun_q, overrun_d;
  logic        rx_meta_q, rx_s;
  logic        load;

  // Two-flop synchronizer; reset to the idle line level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= serial_rx;
      rx_s      <= rx_meta_q;
    end
  end

  // Frame state, bit timing and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      rx_byte_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      rx_byte_q     <= rx_byte_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  // Next-state: start qualification at half bit, then full-bit sampling.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    load          = 1'b0;
    frame_error_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        idx_d   = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (timer_q == HalfLast) begin
          timer_d = '0;
          idx_d   = '0;
          // A high line at mid-start means the falling edge was a glitch.
          state_d = rx_s ? StIdle : StData;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StData: begin
        if (timer_q == BitLast) begin
          timer_d        = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StStop;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StStop: begin
        if (timer_q == BitLast) begin
          timer_d = '0;
          if (rx_s) begin
            load    = 1'b1;
            state_d = StIdle;
          end else begin
            frame_error_d = 1'b1;
            state_d       = StBreak;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StBreak: begin
        // Wait out a held-low line without treating it as a new start bit.
        timer_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output register and handshake; a fresh load always wins over consumption.
  always_comb begin
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (load) begin
      rx_byte_d  = shift_q;
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q && !rx_ready;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  assign rx_byte     = rx_byte_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx with a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned CPB = 104;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       serial_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .serial_rx   (serial_rx),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  int n_err = 0;
  int n_checks = 0;

  // Free-running cycle count and output event monitors (sampled on the falling edge).
  int   cyc = 0;
  int   fe_cnt = 0;
  int   ov_cnt = 0;
  int   rise_cnt = 0;
  int   rise_cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (frame_error === 1'b1) fe_cnt <= fe_cnt + 1;
    if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    prev_valid <= rx_valid;
  end

  // Reference model: what the consumer should see after each whole frame.
  logic [7:0] m_byte = 8'h00;
  logic       m_valid = 1'b0;
  int         m_ov = 0;
  int         m_fe = 0;

  int         start_cyc = 0;
  int         lat;
  int         fe0;
  int         ov0;
  int         r0;
  logic [7:0] d;
  int         gap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    serial_rx = b;
    tick(n);
  endtask

  // One 8N1 frame, LSB first; stop_low > 0 holds the stop bit low that long first.
  task automatic send_frame(input logic [7:0] data, input int stop_low);
    start_cyc = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(data[i], CPB);
    if (stop_low > 0) drive_bit(1'b0, stop_low);
    drive_bit(1'b1, CPB);
  endtask

  // A good frame with rx_ready held constant for its whole duration.
  task automatic model_good(input logic [7:0] data);
    if (m_valid && !rx_ready) m_ov++;
    m_byte  = data;
    m_valid = !rx_ready;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    m_valid  = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_byte"}, {24'd0, rx_byte}, {24'd0, m_byte});
    check({tag, "_valid"}, {31'd0, rx_valid}, {31'd0, m_valid});
    check({tag, "_ovr"}, ov_cnt, m_ov);
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_byte", {24'd0, rx_byte}, 32'd0);
    check("rst_fe", {31'd0, frame_error}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    reset_n = 1'b1;
    tick(20);

    // 0xA5, latency, hold until consumed
    send_frame(8'hA5, 0);
    model_good(8'hA5);
    lat = rise_cyc - start_cyc - 1;
    check("a5_latency_window", {31'd0, (lat >= 988 && lat <= 992)}, 32'd1);
    check_model("a5");
    tick(100);
    check("a5_held", {31'd0, rx_valid}, 32'd1);
    rx_ready = 1'b1;
    tick(1);
    check("a5_ack", {31'd0, rx_valid}, 32'd0);
    rx_ready = 1'b0;
    m_valid  = 1'b0;

    // Short low glitch on idle line
    fe0 = fe_cnt;
    r0  = rise_cnt;
    serial_rx = 1'b0;
    tick(20);
    serial_rx = 1'b1;
    tick(200);
    check("glitch_fe", fe_cnt, fe0);
    check("glitch_rise", rise_cnt, r0);
    check_model("glitch");
    send_frame(8'h3C, 0);
    model_good(8'h3C);
    check_model("3c");

    // Stop bit held low: frame error, previous byte untouched, no restart while low
    send_frame(8'h55, 300);
    m_fe++;
    tick(1100);
    check("brk_fe", fe_cnt, m_fe);
    check_model("brk");
    consume();

    // Back-to-back frames, consumer stalled
    send_frame(8'h01, 0);
    model_good(8'h01);
    send_frame(8'hFE, 0);
    model_good(8'hFE);
    check_model("b2b_stall");
    consume();

    // Back-to-back frames, consumer always ready
    rx_ready = 1'b1;
    send_frame(8'h01, 0);
    model_good(8'h01);
    send_frame(8'hFE, 0);
    model_good(8'hFE);
    check_model("b2b_ready");
    rx_ready = 1'b0;

    // Reset in the middle of data bit 4 of 0xFF
    send_frame(8'h42, 0);
    model_good(8'h42);
    check_model("pre_rst");
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, CPB);
    drive_bit(1'b1, CPB / 2);
    reset_n = 1'b0;
    #2;
    check("arst_valid", {31'd0, rx_valid}, 32'd0);
    check("arst_byte", {24'd0, rx_byte}, 32'd0);
    m_byte  = 8'h00;
    m_valid = 1'b0;
    tick(5);
    reset_n = 1'b1;
    r0 = rise_cnt;
    tick(1200);
    check("arst_no_partial", rise_cnt, r0);
    check_model("arst_idle");
    send_frame(8'h81, 0);
    model_good(8'h81);
    check_model("post_rst");
    consume();

    // Randomized frames, ready and gaps
    for (int k = 0; k < 20; k++) begin
      d        = 8'($urandom);
      rx_ready = 1'($urandom_range(0, 1));
      if (rx_ready) m_valid = 1'b0;
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
      send_frame(d, 0);
      model_good(d);
      check_model("rand");
      if (gap > 0) tick(gap);
    end
    rx_ready = 1'b0;
    tick(5);
    check("final_fe", fe_cnt, m_fe);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, giving clock cycles per serial bit (1 MHz / 9600 baud); legal range 4..65535.
- REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
- REQ-004 SHALL have port serial_rx, input, 1 bit: asynchronous serial line, idle high, 8N1 frame, data LSB first.
- REQ-005 SHALL have port rx_byte, output, 8 bits: last correctly framed received byte.
- REQ-006 SHALL have port rx_valid, output, 1 bit: rx_byte holds an unconsumed byte.
- REQ-007 SHALL have port rx_ready, input, 1 bit: consumer accepts rx_byte when rx_valid and rx_ready are both high at a clock edge.
- REQ-008 SHALL have port frame_error, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- REQ-009 SHALL have port overrun, output, 1 bit: one-cycle pulse when a new byte completes while the previous byte is still unconsumed.

Function
- REQ-010 SHALL pass serial_rx through a 2-flop synchronizer, reset value 1; all later logic uses only the synchronized value (rx_s).
- REQ-011 SHALL implement states IDLE, START, DATA, STOP, BREAK, with a 16-bit bit-timer and a 3-bit bit index.
- REQ-012 IDLE: when rx_s = 0, SHALL go to START with the bit-timer cleared.
- REQ-013 START: at bit-timer = CLKS_PER_BIT/2 - 1 (integer division), SHALL sample rx_s; if 0, go to DATA with timer and index cleared; if 1, treat as a glitch and return to IDLE with no output activity.
- REQ-014 DATA: at bit-timer = CLKS_PER_BIT - 1, SHALL sample rx_s into shift bit [index], clear the timer, and increment the index; after index 7 is sampled, SHALL go to STOP.
- REQ-015 STOP: at bit-timer = CLKS_PER_BIT - 1, SHALL sample rx_s; if 1, load rx_byte from the shift register and go to IDLE; if 0, pulse frame_error, leave rx_byte and rx_valid unchanged, and go to BREAK.
- REQ-016 BREAK: SHALL stay in BREAK until rx_s = 1, then go to IDLE. No start detection in BREAK.
- REQ-017 rx_valid SHALL set in the same cycle rx_byte loads, and clear on the first edge where rx_valid and rx_ready are both high, unless a new byte loads in that same edge.
- REQ-018 A byte loading while rx_valid = 1 and rx_ready = 0 SHALL overwrite rx_byte, keep rx_valid = 1, and pulse overrun.
- REQ-019 A byte loading while rx_valid = 1 and rx_ready = 1 SHALL overwrite rx_byte, keep rx_valid = 1, and not pulse overrun.
- REQ-020 Mid-stop sampling plus the immediate return to IDLE SHALL support back-to-back frames with no idle gap.
- REQ-021 Latency: rx_valid SHALL rise 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (+/-2) cycles after the start-bit falling edge on serial_rx.

Reset
- REQ-022 While reset_n = 0, the block SHALL be in state IDLE with the following values: synchronizer flops = 1, timer = 0, index = 0, shift = 0x00, rx_byte = 0x00, rx_valid = 0, frame_error = 0, overrun = 0.
- REQ-023 Reset asserted mid-frame SHALL abandon the frame immediately. After release, the block SHALL wait for a new falling edge and produce no partial byte.

Verification
- REQ-024 Frame 0xA5 with a valid stop bit and rx_ready = 0 -> rx_valid = 1 and rx_byte = 0xA5 at cycle 990 +/-2 (CLKS_PER_BIT = 104), held until rx_ready = 1, then rx_valid = 0 the next cycle.
- REQ-025 Low glitch of 20 cycles on an idle line -> no rx_valid, frame_error or overrun; the next frame 0x3C is received correctly.
- REQ-026 Frame 0x55 with the stop bit held low for 300 cycles -> one frame_error pulse, rx_byte and rx_valid unchanged, no new start detected until the line returns high.
- REQ-027 Back-to-back frames 0x01 then 0xFE with rx_ready = 0 -> rx_byte = 0xFE, rx_valid = 1, one overrun pulse; the same sequence with rx_ready held 1 -> no overrun.
- REQ-028 reset_n pulsed low during data bit 4 of frame 0xFF -> outputs return to reset values asynchronously, no byte delivered; the following frame 0x81 is received as 0x81.
